// File: rtl/led_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_pkg
// Description : Shared encodings for the LED pattern generator: pattern mode,
//               colour select and ping-pong direction.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROL   = 2'b00,
    MODE_ROR   = 2'b01,
    MODE_PING  = 2'b10,
    MODE_FLASH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    COL_R = 2'b00,
    COL_G = 2'b01,
    COL_B = 2'b10,
    COL_W = 2'b11
  } col_e;

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage : led_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running counter that emits a one-cycle step pulse each
//               time it reaches the limit chosen by i_speed.
// Ports       : clock    - system clock
//               i_reset  - asynchronous active-low reset
//               i_enable - 1 = count, 0 = hold count and suppress o_tick
//               i_clear  - synchronous restart of the period (mode reload)
//               i_speed  - selects LIM0..LIM3
//               o_tick   - registered one-cycle step pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIM0       = 2**23 - 1,
  parameter int unsigned LIM1       = 2**24 - 1,
  parameter int unsigned LIM2       = 2**25 - 1,
  parameter int unsigned LIM3       = 2**26 - 1
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic [1:0] i_speed,
  output logic       o_tick
);

  logic [NB_COUNTER-1:0] count;
  logic [NB_COUNTER-1:0] limit;

  always_comb begin
    limit = NB_COUNTER'(LIM0);
    case (i_speed)
      2'd0:    limit = NB_COUNTER'(LIM0);
      2'd1:    limit = NB_COUNTER'(LIM1);
      2'd2:    limit = NB_COUNTER'(LIM2);
      default: limit = NB_COUNTER'(LIM3);
    endcase
  end

  // ">=" rather than "==": if the limit drops below the current count the
  // tick fires on the next edge instead of the counter wrapping around.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count  <= '0;
      o_tick <= 1'b0;
    end else if (i_clear) begin
      count  <= '0;
      o_tick <= 1'b0;
    end else if (i_enable) begin
      if (count >= limit) begin
        count  <= '0;
        o_tick <= 1'b1;
      end else begin
        count  <= count + 1'b1;
        o_tick <= 1'b0;
      end
    end else begin
      o_tick <= 1'b0;
    end
  end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_pattern_gen
// Description : LED pattern generator. A prescaled step pulse advances an
//               NB_LEDS-bit pattern in rotate-left, rotate-right, ping-pong or
//               flash mode; the pattern is steered onto R/G/B banks.
// Ports       : clock    - system clock
//               i_reset  - asynchronous active-low reset
//               i_enable - 1 = run, 0 = freeze counter and pattern
//               i_speed  - prescaler limit select
//               i_mode   - 00 ROL, 01 ROR, 10 ping-pong, 11 flash
//               i_color  - 00 red, 01 green, 10 blue, 11 white
//               o_led    - current pattern
//               o_led_r/g/b - colour-steered pattern
//               o_tick   - one-cycle step pulse
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int          NB_LEDS    = 4,
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIM0       = 2**23 - 1,
  parameter int unsigned LIM1       = 2**24 - 1,
  parameter int unsigned LIM2       = 2**25 - 1,
  parameter int unsigned LIM3       = 2**26 - 1
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [1:0]         i_speed,
  input  logic [1:0]         i_mode,
  input  logic [1:0]         i_color,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_r,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic               o_tick
);

  localparam logic [NB_LEDS-1:0] PAT_ONE = {{(NB_LEDS-1){1'b0}}, 1'b1};

  mode_e              mode_q;
  dir_e               dir, dir_next;
  logic [NB_LEDS-1:0] pattern, pattern_next;
  logic               reload;
  logic               tick;

  // A mode change restarts the pattern and the prescaler period.
  assign reload = (i_mode != mode_q);

  tick_prescaler #(
    .NB_COUNTER (NB_COUNTER),
    .LIM0       (LIM0),
    .LIM1       (LIM1),
    .LIM2       (LIM2),
    .LIM3       (LIM3)
  ) u_prescaler (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_clear  (reload),
    .i_speed  (i_speed),
    .o_tick   (tick)
  );

  // State register
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      pattern <= PAT_ONE;
      dir     <= DIR_UP;
      mode_q  <= MODE_ROL;
    end else begin
      pattern <= pattern_next;
      dir     <= dir_next;
      mode_q  <= mode_e'(i_mode);
    end
  end

  // Next state: reload wins over a coincident tick, which is dropped.
  always_comb begin
    pattern_next = pattern;
    dir_next     = dir;
    if (reload) begin
      pattern_next = (i_mode == MODE_FLASH) ? '1 : PAT_ONE;
      dir_next     = DIR_UP;
    end else if (tick) begin
      case (mode_q)
        MODE_ROL: pattern_next = {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
        MODE_ROR: pattern_next = {pattern[0], pattern[NB_LEDS-1:1]};
        MODE_PING: begin
          if (dir == DIR_UP) begin
            if (pattern[NB_LEDS-1]) begin
              dir_next     = DIR_DOWN;
              pattern_next = pattern >> 1;
            end else begin
              pattern_next = pattern << 1;
            end
          end else begin
            if (pattern[0]) begin
              dir_next     = DIR_UP;
              pattern_next = pattern << 1;
            end else begin
              pattern_next = pattern >> 1;
            end
          end
        end
        default: pattern_next = ~pattern;
      endcase
    end
  end

  // Outputs: colour steering is purely combinational on i_color.
  always_comb begin
    o_led_r = '0;
    o_led_g = '0;
    o_led_b = '0;
    case (i_color)
      COL_R: o_led_r = pattern;
      COL_G: o_led_g = pattern;
      COL_B: o_led_b = pattern;
      default: begin
        o_led_r = pattern;
        o_led_g = pattern;
        o_led_b = pattern;
      end
    endcase
  end

  assign o_led  = pattern;
  assign o_tick = tick;

endmodule : led_pattern_gen
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Self-checking bench for led_pattern_gen with LIM0..3 = 3,5,7,9
//               and NB_LEDS = 4. Vector table for the steady-state sequences,
//               hand-written sequences for speed change, freeze, mode/tick
//               collision and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

  logic       clock = 1'b0;
  logic       i_reset;
  logic       i_enable;
  logic [1:0] i_speed;
  logic [1:0] i_mode;
  logic [1:0] i_color;
  logic [3:0] o_led, o_led_r, o_led_g, o_led_b;
  logic       o_tick;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_gen #(
    .NB_LEDS    (4),
    .NB_COUNTER (32),
    .LIM0       (3),
    .LIM1       (5),
    .LIM2       (7),
    .LIM3       (9)
  ) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_speed  (i_speed),
    .i_mode   (i_mode),
    .i_color  (i_color),
    .o_led    (o_led),
    .o_led_r  (o_led_r),
    .o_led_g  (o_led_g),
    .o_led_b  (o_led_b),
    .o_tick   (o_tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cycles;
    logic       en;
    logic [1:0] spd;
    logic [1:0] mode;
    logic [1:0] col;
    logic [3:0] led;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  // Advance n rising edges; return 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [16:0] snap();
    return {o_led, o_led_r, o_led_g, o_led_b, o_tick};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int c, input logic en, input logic [1:0] spd, input logic [1:0] mode,
                     input logic [1:0] col, input logic [3:0] led, input logic [3:0] r,
                     input logic [3:0] g, input logic [3:0] b, input logic tick);
    vec_t v;
    v.cycles = c; v.en = en; v.spd = spd; v.mode = mode; v.col = col;
    v.led = led; v.r = r; v.g = g; v.b = b; v.tick = tick;
    vecs.push_back(v);
  endtask

  initial begin
    // Rotate-left from reset, period 4 (LIM0 = 3)
    add(3, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(1, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 0, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 0, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // Colour steering, zero latency
    add(0, 1, 0, 0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0);
    add(0, 1, 0, 0, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0);
    add(0, 1, 0, 0, 3, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0);
    add(0, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // Ping-pong: reload then bounce
    add(1, 1, 0, 2, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 2, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(1, 1, 0, 2, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 2, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 2, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 2, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 2, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 2, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 2, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 2, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 2, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 2, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 2, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 2, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 2, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 2, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0);
    // Flash, white
    add(1, 1, 0, 3, 3, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 0);
    add(3, 1, 0, 3, 3, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 0);
    add(1, 1, 0, 3, 3, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1);
    add(1, 1, 0, 3, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    add(3, 1, 0, 3, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 1, 0, 3, 3, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 0);
    add(0, 1, 0, 3, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 0);

    // Reset: generate a clean falling edge on i_reset
    i_reset = 1'b1; i_enable = 1'b1; i_speed = 2'd0; i_mode = 2'd0; i_color = 2'd0;
    #1 i_reset = 1'b0;
    #1 check("rst_async", snap(), {4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0});
    step(2);
    check("rst_held", snap(), {4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0});
    i_reset = 1'b1;

    foreach (vecs[i]) begin
      i_enable = vecs[i].en;
      i_speed  = vecs[i].spd;
      i_mode   = vecs[i].mode;
      i_color  = vecs[i].col;
      if (vecs[i].cycles == 0) #1;
      else step(vecs[i].cycles);
      check($sformatf("vec%0d", i), snap(),
            {vecs[i].led, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].tick});
    end

    // Speed change: count reaches 6 under LIM3, then drop to LIM0
    i_speed = 2'd3;
    step(5);
    check("spd_pre", {16'h0, o_tick}, 17'd0);
    i_speed = 2'd0;
    step(1);
    check("spd_fire", {12'h0, o_led, o_tick}, {12'h0, 4'b1111, 1'b1});
    step(1);
    check("spd_step", {12'h0, o_led, o_tick}, {12'h0, 4'b0000, 1'b0});
    step(2);
    check("spd_gap", {16'h0, o_tick}, 17'd0);
    step(1);
    check("spd_period", {16'h0, o_tick}, 17'd1);
    step(1);
    check("spd_led", {13'h0, o_led}, {13'h0, 4'b1111});

    // Freeze for 20 cycles with count = 1
    i_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check($sformatf("freeze%0d", i), {12'h0, o_led, o_tick}, {12'h0, 4'b1111, 1'b0});
    end
    i_enable = 1'b1;
    step(2);
    check("thaw_gap", {16'h0, o_tick}, 17'd0);
    step(1);
    check("thaw_tick", {16'h0, o_tick}, 17'd1);
    step(1);
    check("thaw_led", {12'h0, o_led, o_tick}, {12'h0, 4'b0000, 1'b0});

    // Mode change on the exact cycle o_tick is high
    step(3);
    check("coll_pre", {16'h0, o_tick}, 17'd1);
    i_mode = 2'd0;
    step(1);
    check("coll_reload", {12'h0, o_led, o_tick}, {12'h0, 4'b0001, 1'b0});
    step(3);
    check("coll_gap", {16'h0, o_tick}, 17'd0);
    step(1);
    check("coll_tick", {12'h0, o_led, o_tick}, {12'h0, 4'b0001, 1'b1});
    step(1);
    check("coll_step", {13'h0, o_led}, {13'h0, 4'b0010});

    // Asynchronous reset between edges while o_led = 0100 (colour = green)
    step(3);
    step(1);
    check("arst_pre", {13'h0, o_led}, {13'h0, 4'b0100});
    #3 i_reset = 1'b0;
    #1 check("arst_now", snap(), {4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0});
    step(1);
    i_reset = 1'b1;
    step(4);
    check("arst_tick", {12'h0, o_led, o_tick}, {12'h0, 4'b0001, 1'b1});
    step(1);
    check("arst_step", {13'h0, o_led}, {13'h0, 4'b0010});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_led_pattern_gen
`default_nettype wire
